// File: rtl/layer_compositor_pkg.sv
// Shared types and constants for the layer compositor: FSM states, pipeline
// depth and the offset helpers used to seed sprite and screen addresses.
package layer_compositor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BG,
    S_LAYER,
    S_DRAIN,
    S_DONE
  } state_t;

  // ROM read adds one cycle and the VRAM write register adds another.
  localparam int PIPE_DEPTH = 2;

  localparam int DEF_SPRITE_SIZE = 32;
  localparam int DEF_SPRITE_AREA = DEF_SPRITE_SIZE * DEF_SPRITE_SIZE;

  function automatic int sprite_offset(input int idx, input int size);
    return idx * size * size;
  endfunction

  // Seeds the running address of a layer walk; width is a constant at every use.
  function automatic int screen_offset(input int x, input int y, input int width);
    return y * width + x;
  endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Memory-side bundle: sprite/alpha ROM read port and back-buffer VRAM write port.
interface layer_compositor_if #(
  parameter int SPRITEBUF_A_WIDTH = 13,
  parameter int VRAM_A_WIDTH      = 16
);
  logic [SPRITEBUF_A_WIDTH-1:0] sprite_addr;
  logic [7:0]                   sprite_data;
  logic                         sprite_alpha;
  logic [VRAM_A_WIDTH-1:0]      vram_addr;
  logic [7:0]                   vram_data;
  logic                         vram_we;

  modport master (
    output sprite_addr, vram_addr, vram_data, vram_we,
    input  sprite_data, sprite_alpha
  );

  modport slave (
    input  sprite_addr, vram_addr, vram_data, vram_we,
    output sprite_data, sprite_alpha
  );
endinterface

// File: rtl/layer_compositor_raster_walker.sv
// Run/done 2-D counter: x wraps at W, y at H, and a linear address advances by
// 1 per pixel and by ROW_STEP on each row wrap.
module raster_walker #(
  parameter int W        = 320,
  parameter int H        = 180,
  parameter int A_WIDTH  = 16,
  parameter int ROW_STEP = 1,
  localparam int XW = (W > 1) ? $clog2(W) : 1,
  localparam int YW = (H > 1) ? $clog2(H) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base,
  output logic               active,
  output logic               last,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [A_WIDTH-1:0] lin
);

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
      lin    <= '0;
    end else if (start) begin
      active <= 1'b1;
      x      <= '0;
      y      <= '0;
      lin    <= base;
    end else if (active) begin
      if (x == XW'(W - 1)) begin
        x   <= '0;
        lin <= lin + A_WIDTH'(ROW_STEP);
        if (y == YW'(H - 1)) active <= 1'b0;
        else                 y      <= y + 1'b1;
      end else begin
        x   <= x + 1'b1;
        lin <= lin + 1'b1;
      end
    end
  end

  assign last = active && (x == XW'(W - 1)) && (y == YW'(H - 1));

endmodule

// File: rtl/layer_compositor.sv
// Composites a tiled background plus NUM_LAYERS alpha-keyed sprites into the
// back VRAM buffer and swaps front/back only at a screen end after completion.
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int SCREEN_WIDTH      = 320,
  parameter int SCREEN_HEIGHT     = 180,
  parameter int VRAM_A_WIDTH      = 16,
  parameter int SPRITE_SIZE       = DEF_SPRITE_SIZE,
  parameter int SPRITEBUF_A_WIDTH = 13,
  parameter int NUM_LAYERS        = 8,
  parameter int INDEX_WIDTH       = 3,
  parameter int POS_WIDTH         = 10,
  parameter int BG_SPRITE_INDEX   = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   screenend,
  input  logic [NUM_LAYERS-1:0]                  layer_en,
  input  logic [NUM_LAYERS-1:0][POS_WIDTH-1:0]   layer_x,
  input  logic [NUM_LAYERS-1:0][POS_WIDTH-1:0]   layer_y,
  input  logic [NUM_LAYERS-1:0][INDEX_WIDTH-1:0] layer_sprite,
  layer_compositor_if.master                     mem,
  output logic                                   front_sel,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   overrun
);

  localparam int SW  = $clog2(SPRITE_SIZE);
  localparam int LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int BXW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
  localparam int BYW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam logic [SPRITEBUF_A_WIDTH-1:0] BG_OFF =
    SPRITEBUF_A_WIDTH'(sprite_offset(BG_SPRITE_INDEX, SPRITE_SIZE));

  state_t state, state_nx;
  logic [LW-1:0] layer, layer_nx, next_layer;
  logic [1:0]    drain_cnt;
  logic          adv, snap, swap, bg_start, sp_start;

  logic [NUM_LAYERS-1:0]                  en_q;
  logic [NUM_LAYERS-1:0][POS_WIDTH-1:0]   x_q, y_q;
  logic [NUM_LAYERS-1:0][INDEX_WIDTH-1:0] spr_q;

  logic                    bg_active, bg_last, sp_active, sp_last;
  logic [BXW-1:0]          bg_x;
  logic [BYW-1:0]          bg_y;
  logic [SW-1:0]           sp_u, sp_v;
  logic [VRAM_A_WIDTH-1:0] bg_lin, sp_lin, sp_base;

  logic [POS_WIDTH:0]      px, py;
  logic                    in_bounds, issue, bg_d1;
  logic [VRAM_A_WIDTH-1:0] addr_d1;
  logic [PIPE_DEPTH:1]     vld_pipe;

  raster_walker #(
    .W(SCREEN_WIDTH), .H(SCREEN_HEIGHT), .A_WIDTH(VRAM_A_WIDTH), .ROW_STEP(1)
  ) u_bg_walk (
    .clk(clk), .rst(rst), .start(bg_start), .base('0),
    .active(bg_active), .last(bg_last), .x(bg_x), .y(bg_y), .lin(bg_lin)
  );

  // Row wrap jumps from the sprite's right edge back to its left edge one line down.
  raster_walker #(
    .W(SPRITE_SIZE), .H(SPRITE_SIZE), .A_WIDTH(VRAM_A_WIDTH),
    .ROW_STEP(SCREEN_WIDTH - SPRITE_SIZE + 1)
  ) u_sp_walk (
    .clk(clk), .rst(rst), .start(sp_start), .base(sp_base),
    .active(sp_active), .last(sp_last), .x(sp_u), .y(sp_v), .lin(sp_lin)
  );

  assign busy = (state == S_BG) || (state == S_LAYER) || (state == S_DRAIN);

  always_comb begin
    state_nx   = state;
    layer_nx   = layer;
    next_layer = '0;
    adv        = 1'b0;
    bg_start   = 1'b0;
    sp_start   = 1'b0;
    snap       = 1'b0;
    swap       = 1'b0;
    sp_base    = '0;
    case (state)
      S_IDLE:  if (screenend) begin snap = 1'b1; bg_start = 1'b1; state_nx = S_BG; end
      S_BG:    if (bg_last) adv = 1'b1;
      S_LAYER: if (!en_q[layer] || sp_last) begin
                 if (layer == LW'(NUM_LAYERS - 1)) state_nx = S_DRAIN;
                 else begin adv = 1'b1; next_layer = layer + 1'b1; end
               end
      S_DRAIN: if (drain_cnt == 2'(PIPE_DEPTH - 1)) state_nx = S_DONE;
      S_DONE:  if (screenend) begin
                 snap = 1'b1; swap = 1'b1; bg_start = 1'b1; state_nx = S_BG;
               end
      default: state_nx = S_IDLE;
    endcase
    // The walker for the next layer is armed one cycle early so it runs back to back.
    if (adv) begin
      state_nx = S_LAYER;
      layer_nx = next_layer;
      sp_start = en_q[next_layer];
      sp_base  = VRAM_A_WIDTH'(screen_offset(int'(x_q[next_layer]), int'(y_q[next_layer]),
                                             SCREEN_WIDTH));
    end
  end

  assign px        = {1'b0, x_q[layer]} + (POS_WIDTH + 1)'(sp_u);
  assign py        = {1'b0, y_q[layer]} + (POS_WIDTH + 1)'(sp_v);
  assign in_bounds = (px < (POS_WIDTH + 1)'(SCREEN_WIDTH)) &&
                     (py < (POS_WIDTH + 1)'(SCREEN_HEIGHT));
  assign issue     = ((state == S_BG) && bg_active) ||
                     ((state == S_LAYER) && sp_active && in_bounds);

  always_comb begin
    mem.sprite_addr = '0;
    if (state == S_BG)
      mem.sprite_addr = BG_OFF
        + (SPRITEBUF_A_WIDTH'(bg_y & BYW'(SPRITE_SIZE - 1)) << SW)
        + SPRITEBUF_A_WIDTH'(bg_x & BXW'(SPRITE_SIZE - 1));
    else if ((state == S_LAYER) && sp_active)
      mem.sprite_addr = SPRITEBUF_A_WIDTH'(sprite_offset(int'(spr_q[layer]), SPRITE_SIZE))
        + SPRITEBUF_A_WIDTH'({sp_v, sp_u});
  end

  assign mem.vram_we = vld_pipe[PIPE_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      layer         <= '0;
      drain_cnt     <= '0;
      front_sel     <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      en_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      spr_q         <= '0;
      vld_pipe      <= '0;
      bg_d1         <= 1'b0;
      addr_d1       <= '0;
      mem.vram_addr <= '0;
      mem.vram_data <= '0;
    end else begin
      state      <= state_nx;
      layer      <= layer_nx;
      drain_cnt  <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      frame_done <= (state == S_DRAIN) && (state_nx == S_DONE);
      overrun    <= screenend && busy;
      if (swap) front_sel <= ~front_sel;
      if (snap) begin
        en_q  <= layer_en;
        x_q   <= layer_x;
        y_q   <= layer_y;
        spr_q <= layer_sprite;
      end
      // Stage 1 waits for ROM data; stage 2 applies the alpha key (background ignores it).
      vld_pipe[1] <= issue;
      bg_d1       <= (state == S_BG);
      addr_d1     <= (state == S_BG) ? bg_lin : sp_lin;
      vld_pipe[2] <= vld_pipe[1] && (bg_d1 || mem.sprite_alpha);
      if (vld_pipe[1]) begin
        mem.vram_addr <= addr_d1;
        mem.vram_data <= mem.sprite_data;
      end
    end
  end

endmodule
